ir_nec_receiver: RTL and testbench

- Decodes the demodulated IR receiver signal (NEC protocol) into 16-bit address / 8-bit command words for the Rintaro CPU.
- Sits directly upstream of the CPU's IR/irq input: takes the already-inverted `ir` line (1 = carrier burst/mark) and produces a latched code plus a level interrupt held until the CPU acknowledges it.
- Replaces raw bit-banging of `ir` in CPU software.

---
 rtl/ir_nec_pkg.sv | 33 +++
 rtl/ir_sync_filter.sv | 63 ++++++
 rtl/ir_nec_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_ir_nec_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared types and timing windows for the NEC IR receiver. Windows are in 10 us ticks, inclusive.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_M,
        LEAD_S,
        BIT_M,
        BIT_S,
        STOP,
        RPT_M
    } state_t;

    localparam int LEAD_MARK_MIN  = 800;
    localparam int LEAD_MARK_MAX  = 1000;
    localparam int LEAD_SPACE_MIN = 400;
    localparam int LEAD_SPACE_MAX = 500;
    localparam int RPT_SPACE_MIN  = 180;
    localparam int RPT_SPACE_MAX  = 270;
    localparam int BIT_MARK_MIN   = 40;
    localparam int BIT_MARK_MAX   = 75;
    localparam int ZERO_SPACE_MIN = 40;
    localparam int ZERO_SPACE_MAX = 75;
    localparam int ONE_SPACE_MIN  = 140;
    localparam int ONE_SPACE_MAX  = 200;

    localparam int FRAME_BITS = 32;

    function automatic logic in_win(input int d, input int lo, input int hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_sync_filter.sv
// Synchronizes the raw IR line, generates the sample tick and glitch-filters the level.
// rise/fall pulse for one clk in the same cycle the filtered level first shows its new value.
module ir_sync_filter #(
    parameter int TICK_DIV     = 500,
    parameter int FILTER_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ir,
    output logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FILTER_TICKS > 1) ? $clog2(FILTER_TICKS) : 1;

    logic [PW-1:0] pre;
    logic          sync1;
    logic          sync2;
    logic [FW-1:0] fcnt;

    assign tick = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            sync1 <= ir;
            sync2 <= sync1;
        end
    end

    // fcnt counts consecutive tick samples that disagree with the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (sync2 == level) begin
                    fcnt <= '0;
                end else if (fcnt == FW'(FILTER_TICKS - 1)) begin
                    fcnt  <= '0;
                    level <= sync2;
                    rise  <= sync2;
                    fall  <= ~sync2;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR decoder: measures filtered mark/space durations and latches addr/cmd with a level irq until ack.
// Repeat-code decoding is enabled by defining IR_NEC_REPEAT_EN; otherwise repeats abort silently and rpt is 0.
module ir_nec_receiver
    import ir_nec_pkg::*;
#(
    parameter int TICK_DIV     = 500,
    parameter int FILTER_TICKS = 3,
    parameter int CNT_W        = 11
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        ir,
    input  logic        ack,
    output logic [15:0] addr,
    output logic [7:0]  cmd,
    output logic        irq,
    output logic        rpt,
    output logic        overrun,
    output logic        err
);

    logic tick, level, rise, fall;

    ir_sync_filter #(
        .TICK_DIV    (TICK_DIV),
        .FILTER_TICKS(FILTER_TICKS)
    ) u_filt (
        .clk  (clk),
        .rst_n(rst_in),
        .ir   (ir),
        .tick (tick),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       bitcnt;
    logic [31:0]      shift;
    logic             sat, edge_p, mark_end, space_end;
    int               dur;
    logic             w_lead_m, w_lead_s, w_rpt_s, w_bit_m, w_zero, w_one;
    logic             shift_en, shift_bit, frame_ok, rpt_ok, err_p, done;

    assign sat       = &cnt;
    assign edge_p    = rise | fall;
    assign mark_end  = edge_p & ~level;
    assign space_end = edge_p & level;
    assign dur       = int'(cnt);

    assign w_lead_m = in_win(dur, LEAD_MARK_MIN, LEAD_MARK_MAX);
    assign w_lead_s = in_win(dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
    assign w_rpt_s  = in_win(dur, RPT_SPACE_MIN, RPT_SPACE_MAX);
    assign w_bit_m  = in_win(dur, BIT_MARK_MIN, BIT_MARK_MAX);
    assign w_zero   = in_win(dur, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
    assign w_one    = in_win(dur, ONE_SPACE_MIN, ONE_SPACE_MAX);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    // A saturated duration counter outside IDLE means an edge never came
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (space_end) state_nxt = LEAD_M;
            LEAD_M: begin
                if (sat)           state_nxt = IDLE;
                else if (mark_end) state_nxt = w_lead_m ? LEAD_S : IDLE;
            end
            LEAD_S: begin
                if (sat) state_nxt = IDLE;
                else if (space_end) begin
                    state_nxt = IDLE;
                    if (w_lead_s) state_nxt = BIT_M;
`ifdef IR_NEC_REPEAT_EN
                    else if (w_rpt_s) state_nxt = RPT_M;
`endif
                end
            end
            BIT_M: begin
                if (sat) state_nxt = IDLE;
                else if (mark_end) begin
                    if (!w_bit_m)                        state_nxt = IDLE;
                    else if (bitcnt == 6'(FRAME_BITS))   state_nxt = STOP;
                    else                                 state_nxt = BIT_S;
                end
            end
            BIT_S: begin
                if (sat)            state_nxt = IDLE;
                else if (space_end) state_nxt = (w_zero || w_one) ? BIT_M : IDLE;
            end
            STOP:    state_nxt = IDLE;
`ifdef IR_NEC_REPEAT_EN
            RPT_M: begin
                if (sat || mark_end) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef IR_NEC_REPEAT_EN
    logic have_valid;
`endif

    always_comb begin
        err_p     = 1'b0;
        frame_ok  = 1'b0;
        rpt_ok    = 1'b0;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        case (state)
            LEAD_M: err_p = sat | (mark_end & ~w_lead_m);
            LEAD_S: err_p = sat | (space_end & ~w_lead_s & ~w_rpt_s);
            BIT_M:  err_p = sat | (mark_end & ~w_bit_m);
            BIT_S: begin
                if (sat) begin
                    err_p = 1'b1;
                end else if (space_end) begin
                    shift_en  = w_zero | w_one;
                    shift_bit = w_one;
                    err_p     = ~(w_zero | w_one);
                end
            end
            STOP: begin
                frame_ok = (shift[31:24] == ~shift[23:16]);
                err_p    = ~frame_ok;
            end
`ifdef IR_NEC_REPEAT_EN
            RPT_M: begin
                if (sat) begin
                    err_p = 1'b1;
                end else if (mark_end) begin
                    rpt_ok = w_bit_m & have_valid;
                    err_p  = ~(w_bit_m & have_valid);
                end
            end
`endif
            default: ;
        endcase
    end

    assign done = frame_ok | rpt_ok;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            cnt    <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            if (edge_p)            cnt <= '0;
            else if (tick && !sat) cnt <= cnt + 1'b1;
            if (state == LEAD_S)   bitcnt <= '0;
            else if (shift_en)     bitcnt <= bitcnt + 1'b1;
            if (shift_en)          shift <= {shift_bit, shift[31:1]};
        end
    end

    // A completion coinciding with ack counts as the new pending code, not an overrun
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            addr    <= '0;
            cmd     <= '0;
            irq     <= 1'b0;
            overrun <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= err_p;
            if (frame_ok) begin
                addr <= shift[15:0];
                cmd  <= shift[23:16];
            end
            if (done) begin
                irq     <= 1'b1;
                overrun <= ~ack & (overrun | irq);
            end else if (ack) begin
                irq     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

`ifdef IR_NEC_REPEAT_EN
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rpt        <= 1'b0;
            have_valid <= 1'b0;
        end else if (frame_ok) begin
            rpt        <= 1'b0;
            have_valid <= 1'b1;
        end else if (rpt_ok) begin
            rpt <= 1'b1;
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for ir_nec_receiver with a 1-clk sample tick so whole frames fit in a short run.
module tb_ir_nec_receiver;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        ir;
    logic        ack;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        irq;
    logic        rpt;
    logic        overrun;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int err_base;

    ir_nec_receiver #(
        .TICK_DIV    (1),
        .FILTER_TICKS(3),
        .CNT_W       (11)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .ir     (ir),
        .ack    (ack),
        .addr   (addr),
        .cmd    (cmd),
        .irq    (irq),
        .rpt    (rpt),
        .overrun(overrun),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err === 1'b1) err_seen++;

    initial begin
        #3000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        ir = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Nominal-ish timing: leader 850/430, bit mark 50, zero space 50, one space 160
    task automatic send_frame(input logic [31:0] raw, input bit glitch, input bit ack_end);
        bit found;
        drive(1'b1, 850);
        if (glitch) begin
            drive(1'b0, 200);
            drive(1'b1, 2);
            drive(1'b0, 228);
        end else begin
            drive(1'b0, 430);
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 50);
            drive(1'b0, raw[i] ? 160 : 50);
        end
        drive(1'b1, 50);
        ir = 1'b0;
        if (ack_end) begin
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                found = (dut.fall === 1'b1);
            end
            check("ack_align", 32'(found), 32'd1);
            if (found) begin
                @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        end
        drive(1'b0, 100);
    endtask

    initial begin
        rst_in = 1'b0;
        ir     = 1'b0;
        ack    = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rpt", 32'(rpt), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_in = 1'b1;
        repeat (20) @(negedge clk);

        // addr 00FF, cmd 45, with a 2-tick glitch inside the leader space
        err_base = err_seen;
        send_frame({8'hBA, 8'h45, 16'h00FF}, 1'b1, 1'b0);
        check("f1_irq", 32'(irq), 32'h1);
        check("f1_addr", 32'(addr), 32'h00FF);
        check("f1_cmd", 32'(cmd), 32'h45);
        check("f1_rpt", 32'(rpt), 32'h0);
        check("f1_ovr", 32'(overrun), 32'h0);
        check("f1_err", 32'(err_seen - err_base), 32'h0);
        pulse_ack();
        check("f1_ack_irq", 32'(irq), 32'h0);

        // corrupted inverse byte
        err_base = err_seen;
        send_frame({8'hBB, 8'h45, 16'h00FF}, 1'b0, 1'b0);
        check("f2_err", 32'(err_seen - err_base), 32'h1);
        check("f2_irq", 32'(irq), 32'h0);
        check("f2_addr", 32'(addr), 32'h00FF);
        check("f2_cmd", 32'(cmd), 32'h45);

        // short leader mark
        err_base = err_seen;
        drive(1'b1, 700);
        drive(1'b0, 200);
        check("f3_err", 32'(err_seen - err_base), 32'h1);
        check("f3_irq", 32'(irq), 32'h0);

        err_base = err_seen;
        send_frame({8'hE9, 8'h16, 16'h00FF}, 1'b0, 1'b0);
        check("f4_irq", 32'(irq), 32'h1);
        check("f4_cmd", 32'(cmd), 32'h16);
        check("f4_err", 32'(err_seen - err_base), 32'h0);

        // second frame completes in the same cycle as ack
        send_frame({8'hBA, 8'h45, 16'h00FF}, 1'b0, 1'b1);
        check("f5_irq", 32'(irq), 32'h1);
        check("f5_ovr", 32'(overrun), 32'h0);
        check("f5_cmd", 32'(cmd), 32'h45);

        // unacknowledged previous code is overwritten
        send_frame({8'hB9, 8'h46, 16'h00FF}, 1'b0, 1'b0);
        check("f6_irq", 32'(irq), 32'h1);
        check("f6_cmd", 32'(cmd), 32'h46);
        check("f6_ovr", 32'(overrun), 32'h1);
        pulse_ack();
        check("f6_ack_irq", 32'(irq), 32'h0);
        check("f6_ack_ovr", 32'(overrun), 32'h0);

        // repeat code: 900 mark, 225 space, 56 mark
        err_base = err_seen;
        drive(1'b1, 900);
        drive(1'b0, 225);
        drive(1'b1, 56);
        drive(1'b0, 100);
        check("rpt_err", 32'(err_seen - err_base), 32'h0);
        check("rpt_cmd", 32'(cmd), 32'h46);
        check("rpt_addr", 32'(addr), 32'h00FF);
`ifdef IR_NEC_REPEAT_EN
        check("rpt_irq", 32'(irq), 32'h1);
        check("rpt_flag", 32'(rpt), 32'h1);
        pulse_ack();
`else
        check("rpt_irq", 32'(irq), 32'h0);
        check("rpt_flag", 32'(rpt), 32'h0);
`endif
        check("rpt_done_irq", 32'(irq), 32'h0);

        // mark stuck high after the leader runs the counter to saturation
        err_base = err_seen;
        drive(1'b1, 850);
        drive(1'b0, 430);
        drive(1'b1, 2100);
        drive(1'b0, 100);
        check("stuck_err", 32'(err_seen - err_base), 32'h1);
        check("stuck_irq", 32'(irq), 32'h0);

        // reset in the middle of a bit mark
        err_base = err_seen;
        drive(1'b1, 850);
        drive(1'b0, 430);
        drive(1'b1, 50);
        drive(1'b0, 160);
        drive(1'b1, 25);
        rst_in = 1'b0;
        drive(1'b0, 10);
        check("mid_rst_addr", 32'(addr), 32'h0);
        check("mid_rst_cmd", 32'(cmd), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        rst_in = 1'b1;
        drive(1'b0, 100);
        check("mid_rst_errcnt", 32'(err_seen - err_base), 32'h0);
        check("mid_rst_irq2", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
